// File: rtl/traffic_light_ctrl_param.sv
// Two-road (NS/EW) intersection controller with all-red clearance, latched
// pedestrian WALK phase and a night flash mode. Moore outputs only.
module traffic_light_ctrl_param #(
  parameter int GREEN_CYCLES  = 3,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 4,
  parameter int FLASH_HALF    = 2,
  parameter int TIMER_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    NS_GO   = 3'd0,
    NS_WARN = 3'd1,
    AR_A    = 3'd2,
    EW_GO   = 3'd3,
    EW_WARN = 3'd4,
    AR_B    = 3'd5,
    WALK    = 3'd6,
    FLASH   = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Last timer value of each timed state; N-1 always fits since N <= 2**TIMER_W.
  localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(WALK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FLASH_LAST  = TIMER_W'(FLASH_HALF - 1);

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer;
  logic               phase_last;
  logic               flash_on;
  logic               enter_walk;
  logic               enter_flash;

  always_comb begin
    phase_last = 1'b0;
    case (state)
      NS_GO, EW_GO:     phase_last = (timer == GREEN_LAST);
      NS_WARN, EW_WARN: phase_last = (timer == YELLOW_LAST);
      AR_A, AR_B:       phase_last = (timer == ALLRED_LAST);
      WALK:             phase_last = (timer == WALK_LAST);
      FLASH:            phase_last = (timer == FLASH_LAST);
      default:          phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= NS_GO;
    else     state <= state_next;
  end

  // Flash is only entered from an all-red exit, so lamps never jump from
  // green/yellow straight into flashing.
  always_comb begin
    state_next = state;
    case (state)
      NS_GO:   if (phase_last) state_next = NS_WARN;
      NS_WARN: if (phase_last) state_next = AR_A;
      AR_A:    if (phase_last) state_next = flash_en ? FLASH : EW_GO;
      EW_GO:   if (phase_last) state_next = EW_WARN;
      EW_WARN: if (phase_last) state_next = AR_B;
      AR_B: begin
        if (phase_last) begin
          if (flash_en)         state_next = FLASH;
          else if (ped_pending) state_next = WALK;
          else                  state_next = NS_GO;
        end
      end
      WALK:    if (phase_last) state_next = NS_GO;
      FLASH:   if (!flash_en)  state_next = AR_B;
      default: state_next = NS_GO;
    endcase
  end

  assign enter_walk  = (state_next == WALK)  && (state != WALK);
  assign enter_flash = (state_next == FLASH) && (state != FLASH);

  // In FLASH the timer wraps every half-period instead of running to an exit.
  always_ff @(posedge clk) begin
    if (rst)                              timer <= '0;
    else if (state_next != state)         timer <= '0;
    else if (state == FLASH && phase_last) timer <= '0;
    else                                  timer <= timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                               flash_on <= 1'b1;
    else if (enter_flash)                  flash_on <= 1'b1;
    else if (state == FLASH && phase_last) flash_on <= ~flash_on;
  end

  // Clearing on WALK entry wins, so a request arriving on that edge is absorbed.
  always_ff @(posedge clk) begin
    if (rst)                           ped_pending <= 1'b0;
    else if (enter_walk)               ped_pending <= 1'b0;
    else if (ped_req && state != WALK) ped_pending <= 1'b1;
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    walk     = 1'b0;
    case (state)
      NS_GO:   ns_light = LAMP_GRN;
      NS_WARN: ns_light = LAMP_YEL;
      EW_GO:   ew_light = LAMP_GRN;
      EW_WARN: ew_light = LAMP_YEL;
      WALK:    walk     = 1'b1;
      FLASH: begin
        ns_light = flash_on ? LAMP_YEL : LAMP_OFF;
        ew_light = flash_on ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench for traffic_light_ctrl_param: default and shortened-phase
// instances, cycle-by-cycle comparison against hand-derived sequences.
module tb_traffic_light_ctrl_param;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0, flash_en = 1'b0;
  logic       ped2 = 1'b0, flash2 = 1'b0;
  logic [2:0] ns, ew, st, ns2, ew2, st2;
  logic       walk, pend, walk2, pend2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl_param dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_en(flash_en),
    .ns_light(ns), .ew_light(ew), .walk(walk), .ped_pending(pend), .state_o(st)
  );

  traffic_light_ctrl_param #(
    .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(2), .WALK_CYCLES(1)
  ) dut2 (
    .clk(clk), .rst(rst), .ped_req(ped2), .flash_en(flash2),
    .ns_light(ns2), .ew_light(ew2), .walk(walk2), .ped_pending(pend2), .state_o(st2)
  );

  // Safety invariants on both instances, every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((st != 3'd7 && ns != RED && ew != RED) || (walk && (ns != RED || ew != RED))) begin
        failures++;
        $display("FAIL invariant dut st=%0d ns=%b ew=%b walk=%b", st, ns, ew, walk);
      end
      checks++;
      if ((st2 != 3'd7 && ns2 != RED && ew2 != RED) || (walk2 && (ns2 != RED || ew2 != RED))) begin
        failures++;
        $display("FAIL invariant dut2 st=%0d ns=%b ew=%b walk=%b", st2, ns2, ew2, walk2);
      end
    end
  end

  // Default-parameter normal cycle, hand table: {state, ns, ew} for cycle k of the period.
  function automatic logic [8:0] norm(int k);
    case (k % 12)
      0, 1, 2:  return {3'd0, GRN, RED};
      3, 4:     return {3'd1, YEL, RED};
      5:        return {3'd2, RED, RED};
      6, 7, 8:  return {3'd3, RED, GRN};
      9, 10:    return {3'd4, RED, YEL};
      default:  return {3'd5, RED, RED};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; ped_req = 1'b0; flash_en = 1'b0; ped2 = 1'b0; flash2 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst = 1'b1; ped_req = 1'b1; flash_en = 1'b1;
    step();
    step();
    got = {st, ns, ew, walk, pend};
    checks++;
    if (got !== {3'd0, GRN, RED, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", got, {3'd0, GRN, RED, 2'b00});
    end
    rst = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
    step();
    got = {st, ns, ew, walk, pend};
    checks++;
    if (got !== {3'd0, GRN, RED, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", got, {3'd0, GRN, RED, 2'b00});
    end
  endtask

  task automatic test_normal();
    logic [10:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 24; c++) begin
      exp = {norm(c), 1'b0, 1'b0};
      got = {st, ns, ew, walk, pend};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL normal cyc=%0d got=%b exp=%b", c, got, exp);
      end
      step();
    end
  endtask

  // Pulse at 2 latches; request on the WALK-entry edge (11) and during WALK (13) are dropped.
  task automatic test_ped();
    logic [10:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c < 12)       exp = {norm(c), 1'b0, (c >= 3)};
      else if (c <= 15) exp = {3'd6, RED, RED, 1'b1, 1'b0};
      else              exp = {norm(c - 16), 1'b0, 1'b0};
      got = {st, ns, ew, walk, pend};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ped cyc=%0d got=%b exp=%b", c, got, exp);
      end
      ped_req = (c == 2) || (c == 11) || (c == 13);
      step();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_flash();
    logic [10:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 16; c++) begin
      case (c)
        6, 7, 10, 11:  exp = {3'd7, YEL, RED, 1'b0, 1'b0};
        8, 9, 12, 13:  exp = {3'd7, OFF, OFF, 1'b0, 1'b0};
        14:            exp = {3'd5, RED, RED, 1'b0, 1'b0};
        15, 16:        exp = {norm(c - 15), 1'b0, 1'b0};
        default:       exp = {norm(c), 1'b0, 1'b0};
      endcase
      got = {st, ns, ew, walk, pend};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL flash cyc=%0d got=%b exp=%b", c, got, exp);
      end
      flash_en = (c <= 12);
      step();
    end
    flash_en = 1'b0;
  endtask

  task automatic test_flash_ped();
    logic [10:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 13; c++) begin
      case (c)
        6:              exp = {3'd7, YEL, RED, 1'b0, 1'b1};
        7:              exp = {3'd5, RED, RED, 1'b0, 1'b1};
        8, 9, 10, 11:   exp = {3'd6, RED, RED, 1'b1, 1'b0};
        12, 13:         exp = {norm(c - 12), 1'b0, 1'b0};
        default:        exp = {norm(c), 1'b0, (c >= 2)};
      endcase
      got = {st, ns, ew, walk, pend};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL flash_ped cyc=%0d got=%b exp=%b", c, got, exp);
      end
      ped_req  = (c == 1);
      flash_en = (c == 5);
      step();
    end
    ped_req = 1'b0; flash_en = 1'b0;
  endtask

  // Reset pulse in EW_GO also discards a pending request and one arriving with it.
  task automatic test_mid_reset();
    logic [10:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 21; c++) begin
      if (c <= 7) exp = {norm(c), 1'b0, (c >= 3)};
      else        exp = {norm(c - 8), 1'b0, 1'b0};
      got = {st, ns, ew, walk, pend};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", c, got, exp);
      end
      rst     = (c == 7);
      ped_req = (c == 2) || (c == 7);
      step();
    end
    rst = 1'b0; ped_req = 1'b0;
  endtask

  task automatic test_short_params();
    logic [10:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 10; c++) begin
      case (c)
        0, 9:    exp = {3'd0, GRN, RED, 1'b0, 1'b0};
        1:       exp = {3'd1, YEL, RED, 1'b0, 1'b1};
        2, 3:    exp = {3'd2, RED, RED, 1'b0, 1'b1};
        4:       exp = {3'd3, RED, GRN, 1'b0, 1'b1};
        5:       exp = {3'd4, RED, YEL, 1'b0, 1'b1};
        6, 7:    exp = {3'd5, RED, RED, 1'b0, 1'b1};
        8:       exp = {3'd6, RED, RED, 1'b1, 1'b0};
        default: exp = {3'd1, YEL, RED, 1'b0, 1'b0};
      endcase
      got = {st2, ns2, ew2, walk2, pend2};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL short_params cyc=%0d got=%b exp=%b", c, got, exp);
      end
      ped2 = (c == 0);
      step();
    end
    ped2 = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_normal();
    test_ped();
    test_flash();
    test_flash_ped();
    test_mid_reset();
    test_short_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
